// File: rtl/sk_pkg.sv
// Shared types and tree-geometry helpers for the pipelined Sklansky subtractor.
package sk_pkg;

    localparam int SK_WIDTH  = 16;
    localparam int SK_LEVELS = 4;

    typedef logic [SK_WIDTH-1:0] sk_word_t;

    typedef struct packed {
        logic g;
        logic p;
    } sk_gp_t;

    typedef sk_gp_t [SK_WIDTH-1:0] sk_gp_vec_t;

    // At level lvl (span 2**lvl), bit i is a black node when bit lvl-1 of i is set.
    function automatic bit sk_is_black(input int i, input int lvl);
        return ((i >> (lvl - 1)) & 1) == 1;
    endfunction

    // Top bit of the lower half of the block that i belongs to at this level.
    function automatic int sk_partner(input int i, input int lvl);
        return ((i >> lvl) << lvl) + (1 << (lvl - 1)) - 1;
    endfunction

endpackage

// File: rtl/sk_black_cell.sv
// Sklansky black cell: merges a high group (G,P) with the adjacent low group.
module sk_black_cell
    import sk_pkg::*;
(
    input  sk_gp_t hi_i,
    input  sk_gp_t lo_i,
    output sk_gp_t gp_o
);

    assign gp_o.g = hi_i.g | (hi_i.p & lo_i.g);
    assign gp_o.p = hi_i.p & lo_i.p;

endmodule

// File: rtl/sk_sub_pipe_16.sv
// 3-stage Sklansky subtractor diff = a - b - bin with valid/ready flow control.
// Optional SKSUB_FLAGS_EN adds registered signed-overflow and zero flags.
module sk_sub_pipe_16
    import sk_pkg::*;
#(
    parameter int WIDTH   = SK_WIDTH,
    parameter int LATENCY = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    output logic     in_ready,
    input  sk_word_t a,
    input  sk_word_t b,
    input  logic     bin,
    output logic     out_valid,
    input  logic     out_ready,
    output sk_word_t diff,
`ifdef SKSUB_FLAGS_EN
    output logic     ovf,
    output logic     zero,
`endif
    output logic     bout
);

    localparam int STAGES = 3;

    if (WIDTH != SK_WIDTH) begin : g_bad_width
        $error("sk_sub_pipe_16 supports WIDTH=16 only");
    end
    if (LATENCY != STAGES) begin : g_bad_lat
        $error("sk_sub_pipe_16 has a fixed latency of 3");
    end

    logic [STAGES:1] vld_q, vld_d, en, ld;

    // Stage k may load when empty or when stage k+1 frees it this cycle.
    always_comb begin
        en         = '0;
        vld_d      = vld_q;
        en[STAGES] = ~vld_q[STAGES] | out_ready;
        for (int k = STAGES - 1; k >= 1; k--) begin
            en[k] = ~vld_q[k] | en[k+1];
        end
        ld[1] = en[1] & in_valid;
        ld[2] = en[2] & vld_q[1];
        ld[3] = en[3] & vld_q[2];
        if (en[1]) vld_d[1] = in_valid;
        if (en[2]) vld_d[2] = vld_q[1];
        if (en[3]) vld_d[3] = vld_q[2];
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    assign in_ready  = en[1];
    assign out_valid = vld_q[STAGES];

    // Stage 1: bitwise propagate/generate of a + ~b + ~bin.
    sk_word_t p1_d, g1_d, p1_q, g1_q;
    logic     c0_1_d, c0_1_q;

    assign p1_d   = a ^ ~b;
    assign g1_d   = a & ~b;
    assign c0_1_d = ~bin;

    // Tree: node_in[l] feeds level l; levels 1-2 sit before the stage-2 register.
    sk_gp_vec_t node_in  [1:SK_LEVELS];
    sk_gp_vec_t node_out [1:SK_LEVELS];
    sk_gp_vec_t gp2_q;

    for (genvar i = 0; i < SK_WIDTH; i++) begin : g_leaf
        assign node_in[1][i] = {g1_q[i], p1_q[i]};
    end
    assign node_in[2] = node_out[1];
    assign node_in[3] = gp2_q;
    assign node_in[4] = node_out[3];

    for (genvar l = 1; l <= SK_LEVELS; l++) begin : g_lvl
        for (genvar i = 0; i < SK_WIDTH; i++) begin : g_bit
            if (sk_is_black(i, l)) begin : g_black
                sk_black_cell u_cell (
                    .hi_i (node_in[l][i]),
                    .lo_i (node_in[l][sk_partner(i, l)]),
                    .gp_o (node_out[l][i])
                );
            end else begin : g_white
                assign node_out[l][i] = node_in[l][i];
            end
        end
    end

    sk_word_t p2_q;
    logic     c0_2_q;

    // Stage 3: carries from the full prefix, then sum bits.
    logic [SK_WIDTH:0] c;
    sk_word_t          diff_d, diff_q;
    logic              bout_d, bout_q;

    always_comb begin
        c    = '0;
        c[0] = c0_2_q;
        for (int i = 0; i < SK_WIDTH; i++) begin
            c[i+1] = node_out[SK_LEVELS][i].g | (node_out[SK_LEVELS][i].p & c0_2_q);
        end
        diff_d = p2_q ^ c[SK_WIDTH-1:0];
        bout_d = ~c[SK_WIDTH];
    end

    // Datapath registers only move on a load, so idle X inputs never propagate.
    always_ff @(posedge clk) begin
        if (ld[1]) begin
            p1_q   <= p1_d;
            g1_q   <= g1_d;
            c0_1_q <= c0_1_d;
        end
        if (ld[2]) begin
            gp2_q  <= node_out[2];
            p2_q   <= p1_q;
            c0_2_q <= c0_1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (ld[3]) begin
            diff_q <= diff_d;
            bout_q <= bout_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

`ifdef SKSUB_FLAGS_EN
    logic a15_1_q, b15_1_q, a15_2_q, b15_2_q;
    logic ovf_d, ovf_q, zero_d, zero_q;

    assign ovf_d  = (a15_2_q ^ b15_2_q) & (diff_d[SK_WIDTH-1] ^ a15_2_q);
    assign zero_d = ~|diff_d;

    always_ff @(posedge clk) begin
        if (ld[1]) begin
            a15_1_q <= a[SK_WIDTH-1];
            b15_1_q <= b[SK_WIDTH-1];
        end
        if (ld[2]) begin
            a15_2_q <= a15_1_q;
            b15_2_q <= b15_1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (ld[3]) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_sk_sub_pipe_16.sv
// Directed and randomized checks for sk_sub_pipe_16, including backpressure and reset flush.
module tb_sk_sub_pipe_16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        bout;
`ifdef SKSUB_FLAGS_EN
    logic        ovf, zero;
`endif

    sk_sub_pipe_16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
`ifdef SKSUB_FLAGS_EN
        .ovf       (ovf),
        .zero      (zero),
`endif
        .bout      (bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        if (obs !== req) begin
            errs++;
            $display("FAIL %s: got %h, want %h", tag, obs, req);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
        exp_t        e;
        logic [16:0] r;
        r    = {1'b0, ta} - {1'b0, tb_} - {16'b0, tbin};
        e.d  = r[15:0];
        e.bo = r[16];
        e.ov = (ta[15] ^ tb_[15]) & (r[15] ^ ta[15]);
        e.z  = (r[15:0] == 16'h0);
        return e;
    endfunction

    // One clock: drive at the falling edge, then score the handshakes that the next rising edge commits.
    task automatic run_cycle(input logic iv, input logic [15:0] ta, input logic [15:0] tb_,
                             input logic tbin, input logic ordy, output logic acc, output logic took);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        a         = ta;
        b         = tb_;
        bin       = tbin;
        out_ready = ordy;
        #1;
        took = out_valid && out_ready;
        acc  = in_valid && in_ready;
        if (took) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("res", {15'b0, bout, diff}, {15'b0, e.bo, e.d});
`ifdef SKSUB_FLAGS_EN
                chk("flags", {30'b0, ovf, zero}, {30'b0, e.ov, e.z});
`endif
            end
        end
        if (acc) sb.push_back(model(ta, tb_, tbin));
    endtask

    task automatic dir_beat(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                            input logic [15:0] ed, input logic ebo, input logic eov, input logic ez);
        logic acc, took;
        run_cycle(1'b1, ta, tb_, tbin, 1'b1, acc, took);
        chk("dir_acc", acc, 1);
        run_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, took);
        run_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, took);
        chk("dir_lat_early", out_valid, 0);
        run_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, took);
        chk("dir_lat", took, 1);
        chk("dir_diff", {15'b0, bout, diff}, {15'b0, ebo, ed});
`ifdef SKSUB_FLAGS_EN
        chk("dir_flags", {30'b0, ovf, zero}, {30'b0, eov, ez});
`else
        if (eov || ez) begin end
`endif
    endtask

    logic [15:0] bpa [6] = '{16'h1111, 16'h2000, 16'h0005, 16'hABCD, 16'h8000, 16'h0};
    logic [15:0] bpb [6] = '{16'h0111, 16'h3000, 16'h0005, 16'h1234, 16'h7FFF, 16'h0};
    logic        bpc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        logic acc, took;
        int   idx, n, sent, cyc;
        logic iv;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_diff", {15'b0, bout, diff}, 0);
`ifdef SKSUB_FLAGS_EN
        chk("rst_flags", {30'b0, ovf, zero}, 0);
`endif

        dir_beat(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        dir_beat(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        dir_beat(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        dir_beat(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        dir_beat(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        dir_beat(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

        // Backpressure: three accepts fill the pipe, then in_ready must drop.
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            run_cycle(1'b1, bpa[idx], bpb[idx], bpc[idx], 1'b0, acc, took);
            if (acc) idx++;
        end
        chk("bp_accepts", idx, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b1, bpa[idx], bpb[idx], bpc[idx], 1'b0, acc, took);
            chk("bp_hold", {15'b0, bout, diff}, {15'b0, 1'b0, 16'h1000});
            chk("bp_hold_acc", acc, 0);
        end
        n = 0;
        for (int c = 0; c < 30 && (idx < 5 || sb.size() > 0); c++) begin
            run_cycle(idx < 5, bpa[idx], bpb[idx], bpc[idx], 1'b1, acc, took);
            if (acc) idx++;
            if (took) n++;
        end
        chk("bp_count", n, 5);
        chk("bp_sb_empty", sb.size(), 0);

        // Reset with two beats in flight discards them.
        run_cycle(1'b1, 16'h0042, 16'h0001, 1'b0, 1'b0, acc, took);
        run_cycle(1'b1, 16'h0043, 16'h0001, 1'b0, 1'b0, acc, took);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_diff", {15'b0, bout, diff}, 0);
`ifdef SKSUB_FLAGS_EN
        chk("flush_flags", {30'b0, ovf, zero}, 0);
`endif
        sb.delete();
        n = 0;
        for (int c = 0; c < 8; c++) begin
            run_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, took);
            if (took) n++;
        end
        chk("flush_no_stale", n, 0);

        // Random traffic with random stalls on both sides.
        sent = 0;
        cyc  = 0;
        while ((sent < 10000 || sb.size() > 0) && cyc < 60000) begin
            iv = (sent < 10000) && ($urandom_range(0, 3) != 0);
            run_cycle(iv, 16'($urandom), 16'($urandom), 1'($urandom),
                      $urandom_range(0, 3) != 0, acc, took);
            if (acc) sent++;
            cyc++;
        end
        chk("rnd_sent", sent, 10000);
        chk("rnd_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sk_sub_pipe_16.md
Name: sk_sub_pipe_16

Overview:
Pipelined 16-bit Sklansky parallel-prefix subtractor computing diff = a - b - bin, with borrow out. It is the inverse-direction companion to the combinational Sklansky adder in the pipeline_adder library. Internally it uses a + ~b + ~bin with a 4-level Sklansky prefix tree, split across 3 register stages with valid/ready flow control. It sits between operand producers and consumers that can apply backpressure.

Parameters:
WIDTH, 16, operand width; only 16 is supported, so the prefix tree is fixed at 4 levels.
LATENCY, 3, accept-to-output register stages; fixed, documentation only.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  16  minuend
b  input  16  subtrahend
bin  input  1  borrow in
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts the result this cycle
diff  output  16  (a - b - bin) mod 2^16
bout  output  1  borrow out; 1 when a < b + bin (unsigned)
ovf  output  1  signed overflow (only when SKSUB_FLAGS_EN is defined)
zero  output  1  diff == 0 (only when SKSUB_FLAGS_EN is defined)

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clk and rst as elsewhere in the codebase.
- Stage 1 registers:
  - p[i] = a[i] ^ ~b[i], g[i] = a[i] & ~b[i], c0 = ~bin.
  - a[15], b[15] are kept for overflow.
- Stage 2: Sklansky levels 1-2 (span 2 and span 4 group G/P) are registered, along with p and c0.
- Stage 3:
  - Levels 3-4 (span 8 and span 16) complete the tree.
  - Carries: c[i+1] = G[i:0] | P[i:0] & c0.
  - Registered outputs: diff[i] = p[i] ^ c[i]; bout = ~c[16].
- Latency: exactly 3 cycles from an accepted beat to out_valid when out_ready is held 1. Throughput is 1 beat/cycle.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A result is taken when out_valid & out_ready.
  - Each stage has a valid bit. Stage k loads when it is empty or when stage k+1 loads/drains in the same cycle.
  - in_ready = ~v1 | stage-2 load enable. This is combinational from out_ready, with no skid buffer.
- Stall: when out_ready=0 and all 3 stages are full, in_ready=0. diff, bout and the flags hold stable while out_valid=1 and out_ready=0.
- Bubbles: an empty stage is filled even while downstream is stalled (bubble collapse).
- Simultaneous accept and drain on a full pipe: all stages shift and no beat is lost.
- Reset:
  - All valid bits clear to 0, so out_valid=0.
  - diff, bout, ovf and zero reset to 0.
  - in_ready=1 on the first cycle after reset.
  - Reset mid-operation discards all in-flight beats.
- Data registers update only on load, so there is no X propagation from idle inputs.
- Wrap-around: results are modulo 2^16. For example, 0x0000 - 0x0001 gives diff=0xFFFF, bout=1.

Optional Feature:
SKSUB_FLAGS_EN
- Defined:
  - ovf = (a[15] ^ b[15]) & (diff[15] ^ a[15]), carried through the pipe and registered with diff.
  - zero = ~|diff.
  - Both are valid with out_valid and reset to 0.
- Undefined: the ovf and zero ports and their pipeline registers are absent.

Decomposition:
- Package sk_pkg:
  - SK_WIDTH=16, SK_LEVELS=4.
  - typedef sk_word_t = logic [15:0].
  - typedef sk_gp_t, a struct of {g,p} per bit.
- Sub-module sk_black_cell: combinational, computes (Gh | Ph&Gl, Ph&Pl). Instantiated generatively for every tree node. White cells pass G/P through.

Test Plan:
- a=0x1234, b=0x0234, bin=0, out_ready=1 -> 3 cycles later diff=0x1000, bout=0; with FLAGS_EN also ovf=0, zero=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. Then a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
- a=0x5555, b=0x5554, bin=1 -> diff=0x0000, bout=0, zero=1. Then a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1.
- Backpressure:
  - Stream 5 beats with out_ready=0 -> in_ready drops after 3 accepts, and beat 1's diff holds stable.
  - Raise out_ready -> all 5 results emerge in order with no loss or duplication.
- Assert rst for 1 cycle with 2 beats in flight -> next cycle out_valid=0, in_ready=1, outputs 0, and no stale result appears later.
- Random 10,000 beats with random in_valid/out_ready -> every result equals the reference model (a - b - bin) mod 2^16 with the correct bout, in order.
